spin_reel_generator: RTL and testbench

- Producer of the 12-bit spin word consumed by the win-evaluation state: three 4-bit reel digits, reel 0 in [11:8], reel 1 in [7:4], reel 2 in [3:0].
- The play state issues a start pulse. The reels animate, then stop one after another at fixed intervals with pseudo-random digits 0..7. A one-cycle done pulse then hands the final word to the win state.
- A forced-result path lets demos and benches produce 777 or any other pattern deterministically.

---
 rtl/spin_reel_generator.sv | 117 +++++++++++
 tb/tb_spin_reel_generator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spin_reel_generator.sv
// Three-reel spin generator: reels animate, then stop one per REEL_CYCLES with LFSR or forced digits.
// Latency: done pulses 3*REEL_CYCLES edges after start acceptance; start/force inputs are ignored while busy.
module spin_reel_generator #(
  parameter int          REEL_CYCLES = 25000000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        force_en,
  input  logic [11:0] force_spin,
  output logic [11:0] PlayerSpin,
  output logic [2:0]  reel_stopped,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SPIN0, SPIN1, SPIN2} state_t;

  localparam int              CNT_W    = $clog2(REEL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REEL_CYCLES - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0]     SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cycleCnt, cycleCntNext;
  logic [15:0]      lfsr, lfsrNext;
  logic             forced, forcedNext;
  logic [11:0]      forcedSpin, forcedSpinNext;
  logic [11:0]      spinNext;
  logic [2:0]       stoppedNext;
  logic             busyNext, doneNext;
  int               reelIdx;

  always_comb begin
    lfsrNext       = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    stateNext      = state;
    cycleCntNext   = cycleCnt;
    forcedNext     = forced;
    forcedSpinNext = forcedSpin;
    spinNext       = PlayerSpin;
    stoppedNext    = reel_stopped;
    busyNext       = busy;
    doneNext       = 1'b0;
    reelIdx        = 0;

    case (state)
      SPIN0:   reelIdx = 0;
      SPIN1:   reelIdx = 1;
      SPIN2:   reelIdx = 2;
      default: reelIdx = 0;
    endcase

    if (state == IDLE) begin
      if (start) begin
        stateNext      = SPIN0;
        busyNext       = 1'b1;
        stoppedNext    = 3'b000;
        cycleCntNext   = '0;
        forcedNext     = force_en;
        forcedSpinNext = force_spin;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!reel_stopped[i])
          spinNext[11-4*i -: 4] = {1'b0, PlayerSpin[10-4*i -: 3] + 3'd1};
      end

      if (cycleCnt == CNT_LAST) begin
        cycleCntNext = '0;
        // The stop digit overrides this reel's animation step on the same edge.
        for (int i = 0; i < 3; i++) begin
          if (i == reelIdx) begin
            stoppedNext[i]        = 1'b1;
            spinNext[11-4*i -: 4] = forced ? forcedSpin[11-4*i -: 4] : {1'b0, lfsr[2:0]};
          end
        end
        case (state)
          SPIN0:   stateNext = SPIN1;
          SPIN1:   stateNext = SPIN2;
          default: begin
            stateNext = IDLE;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end
        endcase
      end else begin
        cycleCntNext = cycleCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cycleCnt     <= '0;
      lfsr         <= SEED;
      forced       <= 1'b0;
      forcedSpin   <= '0;
      PlayerSpin   <= '0;
      reel_stopped <= 3'b111;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= stateNext;
      cycleCnt     <= cycleCntNext;
      lfsr         <= lfsrNext;
      forced       <= forcedNext;
      forcedSpin   <= forcedSpinNext;
      PlayerSpin   <= spinNext;
      reel_stopped <= stoppedNext;
      busy         <= busyNext;
      done         <= doneNext;
    end
  end

endmodule

// File: tb/tb_spin_reel_generator.sv
// Directed bench for spin_reel_generator with REEL_CYCLES=4; outputs are sampled 1 time unit after each rising edge.
module tb_spin_reel_generator;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        force_en;
  logic [11:0] force_spin;
  logic [11:0] PlayerSpin;
  logic [2:0]  reel_stopped;
  logic        busy;
  logic        done;

  int passCount = 0;
  int checkCount = 0;

  spin_reel_generator #(.REEL_CYCLES(4), .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .resetn(resetn), .start(start), .force_en(force_en),
    .force_spin(force_spin), .PlayerSpin(PlayerSpin), .reel_stopped(reel_stopped),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Reference LFSR built from the documented polynomial and seed.
  logic [15:0] refLfsr;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) refLfsr <= 16'hACE1;
    else         refLfsr <= {refLfsr[14:0], refLfsr[15] ^ refLfsr[13] ^ refLfsr[12] ^ refLfsr[10]};
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag, input logic [11:0] expSpin);
    checkVal({tag, "_spin"}, 32'(PlayerSpin), 32'(expSpin));
    checkVal({tag, "_stopped"}, 32'(reel_stopped), 32'h7);
    checkVal({tag, "_busy"}, 32'(busy), 32'h0);
    checkVal({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // Accepts a spin at the next edge (E0) and drops start again.
  task automatic acceptSpin(input logic fe, input logic [11:0] fs);
    force_en   = fe;
    force_spin = fs;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  function automatic logic [3:0] animNibble(input int initVal, input int k);
    return 4'((initVal + k) % 8);
  endfunction

  logic [11:0] runA [20];
  logic [7:0]  seen [3];
  logic [15:0] snap [3];
  logic [11:0] expWord;
  logic [3:0]  n0, n1, n2;

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    force_en   = 1'b0;
    force_spin = 12'h000;

    // Reset state, then 20 idle cycles with no change.
    repeat (3) tick();
    checkIdleOutputs("reset", 12'h000);
    resetn = 1'b1;
    repeat (20) tick();
    checkIdleOutputs("idle20", 12'h000);

    // Forced jackpot: stop schedule and single done pulse.
    acceptSpin(1'b1, 12'h777);
    checkVal("jack_busy_e0", 32'(busy), 32'h1);
    checkVal("jack_stop_e0", 32'(reel_stopped), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkVal($sformatf("jack_stop_k%0d", k), 32'(reel_stopped),
               32'((k >= 12) ? 3'b111 : (k >= 8) ? 3'b011 : (k >= 4) ? 3'b001 : 3'b000));
      checkVal($sformatf("jack_done_k%0d", k), 32'(done), 32'(k == 12));
      checkVal($sformatf("jack_busy_k%0d", k), 32'(busy), 32'(k != 12));
    end
    checkVal("jack_word", 32'(PlayerSpin), 32'h777);
    tick();
    checkIdleOutputs("jack_after", 12'h777);

    // Animation from a held 777: every reel steps +1 mod 8 until it stops.
    acceptSpin(1'b1, 12'h350);
    checkVal("anim_e0", 32'(PlayerSpin), 32'h777);
    for (int k = 1; k <= 12; k++) begin
      tick();
      n0 = (k >= 4)  ? 4'h3 : animNibble(7, k);
      n1 = (k >= 8)  ? 4'h5 : animNibble(7, k);
      n2 = (k >= 12) ? 4'h0 : animNibble(7, k);
      checkVal($sformatf("anim_k%0d", k), 32'(PlayerSpin), 32'({n0, n1, n2}));
    end

    // Start while busy is ignored, force changes are ignored; held start re-arms after done.
    acceptSpin(1'b1, 12'h123);
    force_spin = 12'h456;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 5 || k == 10 || k == 12);
      tick();
      if (k == 5 || k == 10)
        checkVal($sformatf("busy_ign_stop_k%0d", k), 32'(reel_stopped), 32'((k >= 8) ? 3'b011 : 3'b001));
      if (k != 12) checkVal($sformatf("busy_ign_done_k%0d", k), 32'(done), 32'h0);
    end
    checkVal("busy_ign_done", 32'(done), 32'h1);
    checkVal("busy_ign_word", 32'(PlayerSpin), 32'h123);
    tick();
    start = 1'b0;
    checkVal("b2b_busy", 32'(busy), 32'h1);
    checkVal("b2b_stop", 32'(reel_stopped), 32'h0);
    checkVal("b2b_done", 32'(done), 32'h0);
    repeat (12) tick();
    checkVal("b2b_done_end", 32'(done), 32'h1);
    checkVal("b2b_word", 32'(PlayerSpin), 32'h456);
    tick();

    // Asynchronous reset in the middle of a spin.
    acceptSpin(1'b1, 12'h777);
    repeat (6) tick();
    resetn = 1'b0;
    #1;
    checkIdleOutputs("midreset", 12'h000);
    tick();
    resetn = 1'b1;
    acceptSpin(1'b1, 12'hA5F);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkVal($sformatf("post_rst_done_k%0d", k), 32'(done), 32'(k == 12));
    end
    checkVal("post_rst_word", 32'(PlayerSpin), 32'hA5F);

    // Random spins from a fresh reset, checked against the reference LFSR.
    for (int run = 0; run < 2; run++) begin
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      for (int r = 0; r < 3; r++) seen[r] = 8'h00;
      for (int s = 0; s < 1000; s++) begin
        repeat (s % 5) tick();
        acceptSpin(1'b0, 12'hFFF);
        for (int k = 1; k <= 12; k++) begin
          if (k % 4 == 0) snap[k/4 - 1] = refLfsr;
          tick();
        end
        expWord = {1'b0, snap[0][2:0], 1'b0, snap[1][2:0], 1'b0, snap[2][2:0]};
        if (run == 0) begin
          checkVal($sformatf("rand_word_s%0d", s), 32'(PlayerSpin), 32'(expWord));
          checkVal($sformatf("rand_range_s%0d", s), 32'(PlayerSpin & 12'h888), 32'h0);
          for (int r = 0; r < 3; r++) seen[r][PlayerSpin[10-4*r -: 3]] = 1'b1;
          if (s < 20) runA[s] = PlayerSpin;
        end else if (s < 20) begin
          checkVal($sformatf("determ_s%0d", s), 32'(PlayerSpin), 32'(runA[s]));
        end
        if (run == 1 && s == 19) break;
      end
      if (run == 0)
        for (int r = 0; r < 3; r++)
          checkVal($sformatf("cover_reel%0d", r), 32'(seen[r]), 32'hFF);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
